// File: rtl/sa_ctrl_2x2.sv
// Controller for a 2x2 weight-stationary systolic array: loads the weight rows,
// skews activation vectors into the rows and deskews the column results into out_y.
module sa_ctrl_2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_LAT  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              nvec,
    input  logic [2*DATA_WIDTH-1:0] w_row0,
    input  logic [2*DATA_WIDTH-1:0] w_row1,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_x,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] out_y,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   sa_RD_0,
    output logic [DATA_WIDTH-1:0]   sa_RD_1,
    output logic [DATA_WIDTH-1:0]   sa_FDi_0,
    output logic [DATA_WIDTH-1:0]   sa_FDi_1,
    output logic                    sa_load,
    output logic                    sa_bd_PE_0,
    output logic                    sa_bd_PE_1,
    input  logic [DATA_WIDTH-1:0]   sa_FDo_0,
    input  logic [DATA_WIDTH-1:0]   sa_FDo_1
);
    localparam int DW      = DATA_WIDTH;
    localparam int VLD_LEN = ARRAY_LAT + 2;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                load_ph;
    logic [7:0]          nvec_q;
    logic [7:0]          acc_cnt;
    logic [2*DW-1:0]     w_row0_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                load_q;
    logic [DW-1:0]       fdi0_q;
    logic [DW-1:0]       fdi1_q;
    logic [DW-1:0]       rd0_p0;
    logic [DW-1:0]       x1_p0;
    logic [DW-1:0]       rd1_p1;
    logic                bd0_p0;
    logic                bd1_p1;
    logic [VLD_LEN-1:0]  vld_sr;
    logic [DW-1:0]       fdo0_p1;
    logic                accept;
    logic                last_acc;
    logic                drain_last;

    assign accept     = in_valid & in_ready_q;
    assign last_acc   = accept && ((acc_cnt + 8'd1) == nvec_q);
    // The last result is leaving and nothing else is still inside the array.
    assign drain_last = vld_sr[VLD_LEN-1] && (vld_sr[VLD_LEN-2:0] == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   if (load_ph) state_nxt = (nvec_q == 8'd0) ? S_DONE : S_STREAM;
            S_STREAM: if (last_acc) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            load_ph    <= 1'b0;
            nvec_q     <= '0;
            acc_cnt    <= '0;
            w_row0_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            fdi0_q     <= '0;
            fdi1_q     <= '0;
            rd0_p0     <= '0;
            x1_p0      <= '0;
            rd1_p1     <= '0;
            bd0_p0     <= 1'b0;
            bd1_p1     <= 1'b0;
            vld_sr     <= '0;
            fdo0_p1    <= '0;
        end else begin
            state      <= state_nxt;
            load_ph    <= (state == S_LOAD) && !load_ph;
            in_ready_q <= (state_nxt == S_STREAM);
            busy_q     <= (state_nxt != S_IDLE);
            done_q     <= (state_nxt == S_DONE);
            load_q     <= (state_nxt == S_LOAD);

            if (state == S_IDLE && start) begin
                nvec_q   <= nvec;
                w_row0_q <= w_row0;
            end

            if (state == S_IDLE)
                acc_cnt <= '0;
            else if (accept)
                acc_cnt <= acc_cnt + 8'd1;

            // Row 1 weights go in first so they end up one PE deeper than row 0.
            if (state_nxt == S_LOAD && state == S_IDLE) begin
                fdi0_q <= w_row1[DW-1:0];
                fdi1_q <= w_row1[2*DW-1:DW];
            end else if (state_nxt == S_LOAD) begin
                fdi0_q <= w_row0_q[DW-1:0];
                fdi1_q <= w_row0_q[2*DW-1:DW];
            end else begin
                fdi0_q <= '0;
                fdi1_q <= '0;
            end

            // p0: element 0 enters row 0, element 1 waits one cycle for the row skew
            rd0_p0 <= accept ? in_x[DW-1:0] : '0;
            x1_p0  <= accept ? in_x[2*DW-1:DW] : '0;
            bd0_p0 <= accept && (acc_cnt == 8'd0);
            vld_sr <= {vld_sr[VLD_LEN-2:0], accept};

            // p1: element 1 enters row 1; column 0 result held to line up with column 1
            rd1_p1  <= x1_p0;
            bd1_p1  <= bd0_p0;
            fdo0_p1 <= sa_FDo_0;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sa_load    = load_q;
    assign sa_FDi_0   = fdi0_q;
    assign sa_FDi_1   = fdi1_q;
    assign sa_RD_0    = rd0_p0;
    assign sa_RD_1    = rd1_p1;
    assign sa_bd_PE_0 = bd0_p0;
    assign sa_bd_PE_1 = bd1_p1;
    assign out_valid  = vld_sr[VLD_LEN-1];
    assign out_y      = out_valid ? {sa_FDo_1, fdo0_p1} : '0;

endmodule

// File: tb/tb_sa_ctrl_2x2.sv
// Bench for sa_ctrl_2x2: a behavioural 2x2 array answers the controller, and a
// scoreboard of expected result vectors is checked against out_y and its latency.
module tb_sa_ctrl_2x2;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      nvec = '0;
    logic [2*DW-1:0] w_row0 = '0;
    logic [2*DW-1:0] w_row1 = '0;
    logic            in_valid = 1'b0;
    logic [2*DW-1:0] in_x = '0;
    logic            in_ready, out_valid, busy, done;
    logic [2*DW-1:0] out_y;
    logic [DW-1:0]   sa_RD_0, sa_RD_1, sa_FDi_0, sa_FDi_1;
    logic            sa_load, sa_bd_PE_0, sa_bd_PE_1;
    logic [DW-1:0]   sa_FDo_0 = '0;
    logic [DW-1:0]   sa_FDo_1 = '0;

    sa_ctrl_2x2 #(.DATA_WIDTH(DW), .ARRAY_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .nvec(nvec),
        .w_row0(w_row0), .w_row1(w_row1),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_y(out_y), .busy(busy), .done(done),
        .sa_RD_0(sa_RD_0), .sa_RD_1(sa_RD_1), .sa_FDi_0(sa_FDi_0), .sa_FDi_1(sa_FDi_1),
        .sa_load(sa_load), .sa_bd_PE_0(sa_bd_PE_0), .sa_bd_PE_1(sa_bd_PE_1),
        .sa_FDo_0(sa_FDo_0), .sa_FDo_1(sa_FDo_1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Array model: weights shift down on sa_load, results emerge from a history of row inputs.
    logic [DW-1:0]   h0 [0:LAT+1];
    logic [DW-1:0]   h1 [0:LAT+1];
    logic [2*DW-1:0] mw0 = '0;
    logic [2*DW-1:0] mw1 = '0;

    initial begin
        for (int k = 0; k <= LAT + 1; k++) begin
            h0[k] = '0;
            h1[k] = '0;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = LAT + 1; k > 0; k--) begin
            h0[k] = h0[k-1];
            h1[k] = h1[k-1];
        end
        h0[0] = sa_RD_0;
        h1[0] = sa_RD_1;
        if (sa_load === 1'b1) begin
            mw1 = mw0;
            mw0 = {sa_FDi_1, sa_FDi_0};
        end
        sa_FDo_0 = h0[LAT] * mw0[DW-1:0] + h1[LAT-1] * mw1[DW-1:0];
        sa_FDo_1 = h0[LAT+1] * mw0[2*DW-1:DW] + h1[LAT] * mw1[2*DW-1:DW];
    end

    function automatic logic [2*DW-1:0] ref_y(input logic [2*DW-1:0] x,
                                              input logic [2*DW-1:0] w0,
                                              input logic [2*DW-1:0] w1);
        logic [DW-1:0] y0, y1;
        y0 = x[DW-1:0] * w0[DW-1:0]     + x[2*DW-1:DW] * w1[DW-1:0];
        y1 = x[DW-1:0] * w0[2*DW-1:DW]  + x[2*DW-1:DW] * w1[2*DW-1:DW];
        return {y1, y0};
    endfunction

    typedef struct {
        logic [2*DW-1:0] y;
        int              cyc;
    } exp_t;

    exp_t            sb_q[$];
    exp_t            e;
    logic [2*DW-1:0] job_w0 = '0;
    logic [2*DW-1:0] job_w1 = '0;
    int              cyc = 0;
    int              out_cnt = 0;
    int              done_cnt = 0;
    logic            rst_prev = 1'b1;
    logic [DW-1:0]   exp_rd0 = '0, exp_rd1 = '0, exp_x1 = '0;
    logic            exp_bd0 = 1'b0, exp_bd1 = 1'b0, first_vec = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_prev) begin
            check_eq("rst_busy", busy, 0);
            check_eq("rst_in_ready", in_ready, 0);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_load", sa_load, 0);
            check_eq("rst_rd0", sa_RD_0, 0);
            check_eq("rst_rd1", sa_RD_1, 0);
            check_eq("rst_fdi", {sa_FDi_1, sa_FDi_0}, 0);
            check_eq("rst_bd", {sa_bd_PE_1, sa_bd_PE_0}, 0);
            check_eq("rst_out_y", out_y, 0);
            sb_q.delete();
            exp_rd0 = '0; exp_rd1 = '0; exp_x1 = '0;
            exp_bd0 = 1'b0; exp_bd1 = 1'b0; first_vec = 1'b1;
        end else begin
            check_eq("rd0", sa_RD_0, exp_rd0);
            check_eq("rd1", sa_RD_1, exp_rd1);
            check_eq("bd_pe0", sa_bd_PE_0, exp_bd0);
            check_eq("bd_pe1", sa_bd_PE_1, exp_bd1);
        end

        if (out_valid === 1'b1) begin
            out_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("spurious_out_valid", out_valid, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq("out_y", out_y, e.y);
                check_eq("out_latency", cyc - e.cyc, LAT + 2);
            end
        end

        exp_rd1 = exp_x1;
        exp_bd1 = exp_bd0;
        if (in_valid && in_ready === 1'b1 && !rst) begin
            e.y   = ref_y(in_x, job_w0, job_w1);
            e.cyc = cyc;
            sb_q.push_back(e);
            exp_rd0   = in_x[DW-1:0];
            exp_x1    = in_x[2*DW-1:DW];
            exp_bd0   = first_vec;
            first_vec = 1'b0;
        end else begin
            exp_rd0 = '0;
            exp_x1  = '0;
            exp_bd0 = 1'b0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            first_vec = 1'b1;
        end
        rst_prev = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n, input logic [2*DW-1:0] w1, input logic [2*DW-1:0] w0);
        job_w0 = w0;
        job_w1 = w1;
        out_cnt = 0;
        start = 1'b1; nvec = n; w_row1 = w1; w_row0 = w0;
        tick();
        start = 1'b0; nvec = 8'hAA; w_row1 = '1; w_row0 = '1;
        check_eq("load1_sa_load", sa_load, 1);
        check_eq("load1_fdi1", sa_FDi_1, w1[2*DW-1:DW]);
        check_eq("load1_fdi0", sa_FDi_0, w1[DW-1:0]);
        check_eq("load1_in_ready", in_ready, 0);
        check_eq("load1_busy", busy, 1);
        tick();
        check_eq("load2_sa_load", sa_load, 1);
        check_eq("load2_fdi1", sa_FDi_1, w0[2*DW-1:DW]);
        check_eq("load2_fdi0", sa_FDi_0, w0[DW-1:0]);
        tick();
        check_eq("load_end_sa_load", sa_load, 0);
        check_eq("load_end_fdi", {sa_FDi_1, sa_FDi_0}, 0);
    endtask

    task automatic send_vec(input logic [2*DW-1:0] x);
        int t = 0;
        in_valid = 1'b1;
        in_x = x;
        while (in_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check_eq("send_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_x = '0;
    endtask

    task automatic wait_done(input int n_exp);
        int t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", done, 1);
        check_eq("done_in_ready", in_ready, 0);
        check_eq("out_count", out_cnt, n_exp);
        tick();
        check_eq("done_pulse_len", done, 0);
        check_eq("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic job with the reference weights, two back-to-back vectors.
        start_job(8'd2, {16'd4, 16'd3}, {16'd2, 16'd1});
        send_vec({16'd6, 16'd5});
        send_vec({16'd8, 16'd7});
        wait_done(2);
        tick();

        // Three vectors with in_valid held high.
        start_job(8'd3, {16'd9, 16'd7}, {16'd5, 16'd3});
        send_vec({16'd1, 16'd2});
        send_vec({16'd3, 16'd4});
        send_vec({16'hFFFF, 16'h8000});
        wait_done(3);

        // Two vectors separated by a two-cycle bubble.
        start_job(8'd2, {16'd11, 16'd13}, {16'd17, 16'd19});
        send_vec({16'd21, 16'd23});
        repeat (2) tick();
        send_vec({16'd25, 16'd27});
        wait_done(2);

        // Empty job.
        start_job(8'd0, {16'd1, 16'd1}, {16'd1, 16'd1});
        check_eq("nvec0_done", done, 1);
        check_eq("nvec0_in_ready", in_ready, 0);
        wait_done(0);

        // A start pulse during STREAM must not change the job.
        start_job(8'd3, {16'd2, 16'd3}, {16'd4, 16'd5});
        send_vec({16'd10, 16'd20});
        start = 1'b1; nvec = 8'd7; w_row1 = {16'd99, 16'd98}; w_row0 = {16'd97, 16'd96};
        tick();
        start = 1'b0;
        check_eq("restart_ignored_load", sa_load, 0);
        send_vec({16'd30, 16'd40});
        send_vec({16'd50, 16'd60});
        wait_done(3);

        // Reset in DRAIN with one result still inside the array.
        start_job(8'd1, {16'd3, 16'd3}, {16'd3, 16'd3});
        send_vec({16'd7, 16'd7});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("post_rst_out_valid", out_valid, 0);
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_busy", busy, 0);
        end

        // Reset and start together: reset wins.
        rst = 1'b1; start = 1'b1; nvec = 8'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        check_eq("rst_start_busy", busy, 0);
        check_eq("rst_start_load", sa_load, 0);
        tick();

        // Full-size job, occasional bubbles.
        start_job(8'd255, {16'h1234, 16'h0F0F}, {16'h00FF, 16'hA5A5});
        for (int i = 0; i < 255; i++) begin
            send_vec($urandom);
            if (i % 17 == 0) tick();
        end
        wait_done(255);

        repeat (4) tick();
        check_eq("done_total", done_cnt, 6);
        check_eq("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
